psum_collector: RTL and testbench

Output-side drain stage for the input-stationary systolic array. It captures the bottom-row `psum_out` values of all columns, removes the one-cycle-per-column skew, and narrows each value to `OUT_WIDTH`. It then buffers the aligned rows in a FIFO with a valid/ready output and gives the array controller a conservative `stall` back-pressure signal.

---
 rtl/psum_collector_if.sv | 33 +++
 rtl/psum_collector.sv | 163 ++++++++++++++++
 tb/tb_psum_collector.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/psum_collector_if.sv
// -----------------------------------------------------------------------------
// psum_collector_if
// Bundles the row input, back-pressure, output handshake and status signals of
// psum_collector. clk and rst_n stay as plain module ports.
//   master : array controller / consumer side (drives in_valid, in_psum,
//            out_ready; observes stall, out_valid, out_data, count, overflow)
//   slave  : psum_collector itself
// -----------------------------------------------------------------------------
interface psum_collector_if #(
  parameter int NUM_COLS   = 4,
  parameter int PSUM_WIDTH = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
);
  logic                              in_valid;
  logic [NUM_COLS*PSUM_WIDTH-1:0]    in_psum;
  logic                              stall;
  logic                              out_valid;
  logic                              out_ready;
  logic [NUM_COLS*OUT_WIDTH-1:0]     out_data;
  logic [$clog2(FIFO_DEPTH):0]       count;
  logic                              overflow;

  modport master (
    output in_valid, in_psum, out_ready,
    input  stall, out_valid, out_data, count, overflow
  );

  modport slave (
    input  in_valid, in_psum, out_ready,
    output stall, out_valid, out_data, count, overflow
  );
endinterface

// File: rtl/psum_collector.sv
// -----------------------------------------------------------------------------
// psum_collector
// Drain stage for the input-stationary systolic array. Captures the skewed
// bottom-row partial sums (column c arrives c cycles after column 0), realigns
// them into one row, narrows each column to OUT_WIDTH and buffers rows in a
// FIFO with a valid/ready output. stall is a conservative back-pressure flag:
// occupancy plus rows still in the deskew pipeline, without credit for a pop
// happening in the same cycle.
//
// Ports:
//   clk    : clock
//   rst_n  : synchronous, active-low reset
//   bus    : psum_collector_if.slave (in_valid, in_psum, stall, out_valid,
//            out_ready, out_data, count, overflow)
//
// Build option:
//   PSUM_COLLECTOR_SAT_EN : defined   -> signed saturation to OUT_WIDTH
//                           undefined -> two's complement truncation
// -----------------------------------------------------------------------------
module psum_collector #(
  parameter int NUM_COLS   = 4,
  parameter int PSUM_WIDTH = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  psum_collector_if.slave   bus
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int VPW = (NUM_COLS > 1) ? NUM_COLS - 1 : 1;
  localparam int IW  = $clog2(NUM_COLS) + 1;
  localparam int RW  = NUM_COLS * OUT_WIDTH;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  // Per-column narrowing applied when the aligned row is pushed.
  function automatic logic [OUT_WIDTH-1:0] narrow(input logic signed [PSUM_WIDTH-1:0] v);
`ifdef PSUM_COLLECTOR_SAT_EN
    logic signed [PSUM_WIDTH-1:0] max_v;
    logic signed [PSUM_WIDTH-1:0] min_v;
    max_v = {{(PSUM_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    min_v = {{(PSUM_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    if (v > max_v)      return max_v[OUT_WIDTH-1:0];
    else if (v < min_v) return min_v[OUT_WIDTH-1:0];
    else                return v[OUT_WIDTH-1:0];
`else
    return v[OUT_WIDTH-1:0];
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Deskew: column c is delayed NUM_COLS-1-c cycles so every column of a row
  // lines up with the push strobe. The last column needs no delay.
  // ---------------------------------------------------------------------------
  logic [PSUM_WIDTH-1:0] w_col [NUM_COLS];

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    localparam int D = NUM_COLS - 1 - c;
    if (D == 0) begin : g_direct
      assign w_col[c] = bus.in_psum[c*PSUM_WIDTH +: PSUM_WIDTH];
    end else begin : g_delay
      logic [PSUM_WIDTH-1:0] r_d [D];
      // NOTE: delay lines and FIFO storage are reset explicitly so nothing
      // captured before a reset can ever surface on out_data afterwards.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 0; k < D; k++) r_d[k] <= '0;
        end else begin
          // NOTE: non-blocking assignments make each stage take the previous
          // stage's old value, giving a true shift register.
          r_d[0] <= bus.in_psum[c*PSUM_WIDTH +: PSUM_WIDTH];
          for (int k = 1; k < D; k++) r_d[k] <= r_d[k-1];
        end
      end
      assign w_col[c] = r_d[D-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Row valid pipeline: in_valid delayed NUM_COLS-1 stages; its tail is the
  // push strobe. With one column there is no pipeline and in_valid pushes.
  // ---------------------------------------------------------------------------
  logic [VPW-1:0] r_vpipe;
  logic           w_push;

  if (NUM_COLS > 1) begin : g_vpipe
    always_ff @(posedge clk) begin
      if (!rst_n) r_vpipe <= '0;
      else        r_vpipe <= VPW'({r_vpipe, bus.in_valid});
    end
    assign w_push = r_vpipe[VPW-1];
  end else begin : g_no_vpipe
    always_ff @(posedge clk) r_vpipe <= '0;
    assign w_push = bus.in_valid;
  end

  // Aligned, narrowed row presented to the FIFO write port.
  logic [RW-1:0] w_row;
  always_comb begin
    // NOTE: default first so every bit is assigned on every pass (no latch).
    w_row = '0;
    for (int c = 0; c < NUM_COLS; c++)
      w_row[c*OUT_WIDTH +: OUT_WIDTH] = narrow(signed'(w_col[c]));
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [RW-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           r_overflow;

  logic w_pop;
  logic w_full;
  logic w_push_ok;
  logic w_drop;

  assign w_pop     = (r_count != '0) && bus.out_ready;
  assign w_full    = (r_count == DEPTH_C);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= w_row;
        r_wr_ptr        <= r_wr_ptr + 1'b1;   // power-of-2 depth: wraps freely
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Rows already accepted by the deskew pipeline but not yet pushed.
  logic [IW-1:0] w_inflight;
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < VPW; i++) w_inflight = w_inflight + IW'(r_vpipe[i]);
  end

  // Conservative: a pop in this same cycle is not credited.
  assign bus.stall     = (int'(r_count) + int'(w_inflight)) >= FIFO_DEPTH;
  assign bus.out_valid = (r_count != '0);
  assign bus.out_data  = r_mem[r_rd_ptr];
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_psum_collector.sv
module tb_psum_collector;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  psum_collector_if #(.NUM_COLS(4), .PSUM_WIDTH(32), .OUT_WIDTH(16), .FIFO_DEPTH(8)) u_if ();

  psum_collector #(.NUM_COLS(4), .PSUM_WIDTH(32), .OUT_WIDTH(16), .FIFO_DEPTH(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  // History of rows started over the last 4 cycles; column c of the row started
  // c cycles ago is what the skewed array presents this cycle.
  logic [3:0]            hv;
  logic [3:0][3:0][31:0] hd;

  function automatic logic [3:0][31:0] mkrow(input int a, input int b, input int c, input int d);
    logic [3:0][31:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  function automatic logic [63:0] ex(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start (v=1) or skip a row this cycle, drive the skewed columns, advance one edge.
  task automatic drive(input logic v, input logic [3:0][31:0] d);
    for (int k = 3; k > 0; k--) begin
      hv[k] = hv[k-1];
      hd[k] = hd[k-1];
    end
    hv[0] = v;
    hd[0] = d;
    u_if.in_valid = v;
    for (int c = 0; c < 4; c++)
      u_if.in_psum[c*32 +: 32] = hv[c] ? hd[c][c] : 32'h0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    hv    = '0;
    hd    = '0;
    rst_n = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.in_psum   = '0;
    u_if.out_ready = 1'b0;

    // ---- reset state ----
    idle(2);
    check("rst_out_valid", 64'(u_if.out_valid), 64'd0);
    check("rst_count",     64'(u_if.count),     64'd0);
    check("rst_overflow",  64'(u_if.overflow),  64'd0);
    check("rst_stall",     64'(u_if.stall),     64'd0);
    check("rst_out_data",  u_if.out_data,       64'd0);
    rst_n = 1'b1;
    idle(1);

    // ---- 1: single skewed row, latency 3 edges ----
    u_if.out_ready = 1'b1;
    drive(1'b1, mkrow(1, 2, 3, 4));
    check("t1_valid_e0", 64'(u_if.out_valid), 64'd0);
    idle(1);
    check("t1_valid_e1", 64'(u_if.out_valid), 64'd0);
    idle(1);
    check("t1_valid_e2", 64'(u_if.out_valid), 64'd0);
    idle(1);
    check("t1_valid_e3", 64'(u_if.out_valid), 64'd1);
    check("t1_data",     u_if.out_data,       ex(1, 2, 3, 4));
    idle(1);
    check("t1_valid_e4", 64'(u_if.out_valid), 64'd0);
    check("t1_count_e4", 64'(u_if.count),     64'd0);

    // ---- 2: back-to-back rows, values 10r+c ----
    for (int r = 0; r < 4; r++)
      drive(1'b1, mkrow(10*r, 10*r+1, 10*r+2, 10*r+3));
    check("t2_row0", u_if.out_data, 64'h0003_0002_0001_0000);
    check("t2_cnt0", 64'(u_if.count), 64'd1);
    idle(1);
    check("t2_row1", u_if.out_data, 64'h000D_000C_000B_000A);
    check("t2_cnt1", 64'(u_if.count), 64'd1);
    idle(1);
    check("t2_row2", u_if.out_data, 64'h0017_0016_0015_0014);
    check("t2_cnt2", 64'(u_if.count), 64'd1);
    idle(1);
    check("t2_row3", u_if.out_data, 64'h0021_0020_001F_001E);
    check("t2_vld3", 64'(u_if.out_valid), 64'd1);
    idle(1);
    check("t2_empty", 64'(u_if.out_valid), 64'd0);

    // ---- 3: fill until stall ----
    u_if.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("t3_stall_low", 64'(u_if.stall), 64'd0);
      drive(1'b1, mkrow(k+1, k+2, k+3, k+4));
    end
    check("t3_stall_high", 64'(u_if.stall), 64'd1);
    check("t3_count5",     64'(u_if.count), 64'd5);
    idle(3);
    check("t3_count8",     64'(u_if.count), 64'd8);
    check("t3_stall_full", 64'(u_if.stall), 64'd1);
    check("t3_head",       u_if.out_data,   ex(1, 2, 3, 4));
    u_if.out_ready = 1'b1;
    idle(1);
    u_if.out_ready = 1'b0;
    check("t3_count7",     64'(u_if.count), 64'd7);
    check("t3_stall_drop", 64'(u_if.stall), 64'd0);
    check("t3_head2",      u_if.out_data,   ex(2, 3, 4, 5));

    // ---- 4: overflow, then full with simultaneous pop and push ----
    drive(1'b1, mkrow(9, 10, 11, 12));
    check("t4_stall_inflight", 64'(u_if.stall), 64'd1);
    idle(3);
    check("t4_count8", 64'(u_if.count), 64'd8);
    drive(1'b1, mkrow(99, 99, 99, 99));
    idle(2);
    check("t4_ovf_before", 64'(u_if.overflow), 64'd0);
    idle(1);
    check("t4_ovf_set",    64'(u_if.overflow), 64'd1);
    check("t4_count_drop", 64'(u_if.count),    64'd8);
    check("t4_head_keep",  u_if.out_data,      ex(2, 3, 4, 5));
    drive(1'b1, mkrow(50, 51, 52, 53));
    idle(2);
    u_if.out_ready = 1'b1;
    idle(1);
    check("t4_count_pp", 64'(u_if.count),    64'd8);
    check("t4_ovf_pp",   64'(u_if.overflow), 64'd1);
    for (int k = 2; k < 8; k++) begin
      check("t4_drain_valid", 64'(u_if.out_valid), 64'd1);
      check("t4_drain_data",  u_if.out_data, ex(k+1, k+2, k+3, k+4));
      idle(1);
    end
    check("t4_drain_row8", u_if.out_data, ex(9, 10, 11, 12));
    idle(1);
    check("t4_drain_rowy", u_if.out_data, ex(50, 51, 52, 53));
    idle(1);
    check("t4_drained", 64'(u_if.out_valid), 64'd0);
    check("t4_count0",  64'(u_if.count),     64'd0);

    // ---- 5: narrowing ----
    u_if.out_ready = 1'b0;
    drive(1'b1, mkrow(70000, -70000, 100, -1));
    idle(3);
    check("t5_count", 64'(u_if.count), 64'd1);
`ifdef PSUM_COLLECTOR_SAT_EN
    check("t5_sat",   u_if.out_data, 64'hFFFF_0064_8000_7FFF);
`else
    check("t5_trunc", u_if.out_data, 64'hFFFF_0064_EE90_1170);
`endif
    u_if.out_ready = 1'b1;
    idle(1);
    check("t5_popped", 64'(u_if.count), 64'd0);

    // ---- 6: reset with 3 rows buffered and 2 in flight ----
    u_if.out_ready = 1'b0;
    for (int r = 0; r < 3; r++)
      drive(1'b1, mkrow(60+r, 61+r, 62+r, 63+r));
    idle(3);
    check("t6_count3", 64'(u_if.count), 64'd3);
    drive(1'b1, mkrow(80, 81, 82, 83));
    drive(1'b1, mkrow(90, 91, 92, 93));
    check("t6_ovf_pre", 64'(u_if.overflow), 64'd1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("t6_out_valid", 64'(u_if.out_valid), 64'd0);
    check("t6_count",     64'(u_if.count),     64'd0);
    check("t6_overflow",  64'(u_if.overflow),  64'd0);
    check("t6_stall",     64'(u_if.stall),     64'd0);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check("t6_no_stale", 64'(u_if.out_valid), 64'd0);
    end
    drive(1'b1, mkrow(7, 8, 9, 10));
    idle(3);
    check("t6_fresh_valid", 64'(u_if.out_valid), 64'd1);
    check("t6_fresh_data",  u_if.out_data, ex(7, 8, 9, 10));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
